// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the DIV/DIVU sequencer: FSM state encodings,
// ready/start levels and the EX-side aluop codes that select the divider.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // True for the two aluops that EX must route to the divider.
  function automatic logic is_div_op(input logic [7:0] aluop);
    return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compares the shifted partial remainder with
// the divisor and returns the updated remainder and the new quotient bit.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   i_rem_shifted,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_q_bit
);

  logic [DATA_W:0] w_sub;

  // A set top bit means the shifted remainder already exceeds any divisor;
  // the low-order difference is then exact modulo 2^DATA_W.
  assign w_sub   = {1'b0, i_rem_shifted[DATA_W-1:0]} - {1'b0, i_divisor};
  assign o_q_bit = i_rem_shifted[DATA_W] | ~w_sub[DATA_W];
  assign o_rem   = o_q_bit ? w_sub[DATA_W-1:0] : i_rem_shifted[DATA_W-1:0];

endmodule

// File: rtl/div_ctrl.sv
// Iterative signed/unsigned divider with sequencing FSM for DIV/DIVU.
// Optional macro DIV_ZERO_FLAG_EN enables the registered div_zero_o flag.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  div_zero_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_dividend;
  logic [DATA_W-1:0]   r_divisor;
  logic [DATA_W-1:0]   r_rem;
  logic                r_sign_q;
  logic                r_sign_r;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;
  logic                r_busy;

  logic                w_accept;
  logic                w_op2_zero;
  logic [DATA_W-1:0]   w_op1_abs;
  logic [DATA_W-1:0]   w_op2_abs;
  logic [DATA_W:0]     w_rem_shifted;
  logic [DATA_W-1:0]   w_step_rem;
  logic                w_q_bit;
  logic [DATA_W-1:0]   w_quo_nxt;

  function automatic logic [DATA_W-1:0] neg_if(input logic i_en, input logic [DATA_W-1:0] i_val);
    if (i_en) begin
      return ~i_val + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      return i_val;
    end
  endfunction

  assign w_accept   = (start_i == DIV_START) && !annul_i;
  assign w_op2_zero = (opdata2_i == {DATA_W{1'b0}});
  assign w_op1_abs  = neg_if(signed_div_i & opdata1_i[DATA_W-1], opdata1_i);
  assign w_op2_abs  = neg_if(signed_div_i & opdata2_i[DATA_W-1], opdata2_i);

  // The dividend register doubles as the quotient shift register.
  assign w_rem_shifted = {r_rem, r_dividend[DATA_W-1]};
  assign w_quo_nxt     = {r_dividend[DATA_W-2:0], w_q_bit};

  div_step #(.DATA_W(DATA_W)) u_div_step (
    .i_rem_shifted (w_rem_shifted),
    .i_divisor     (r_divisor),
    .o_rem         (w_step_rem),
    .o_q_bit       (w_q_bit)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= DIV_FREE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_FREE: begin
        if (w_accept) begin
          w_state_nxt = w_op2_zero ? DIV_BY_ZERO : DIV_ON;
        end else begin
          w_state_nxt = DIV_FREE;
        end
      end
      DIV_BY_ZERO: w_state_nxt = DIV_END;
      DIV_ON: begin
        if (annul_i) begin
          w_state_nxt = DIV_FREE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = DIV_END;
        end else begin
          w_state_nxt = DIV_ON;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          w_state_nxt = DIV_FREE;
        end else begin
          w_state_nxt = DIV_END;
        end
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

`ifdef DIV_ZERO_FLAG_EN
  logic r_by_zero;
  logic r_div_zero;
  assign div_zero_o = r_div_zero;
`else
  assign div_zero_o = 1'b0;
`endif

  // Signs are fixed up on the last step so END only has to publish the result.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt      <= {CNT_W{1'b0}};
      r_dividend <= {DATA_W{1'b0}};
      r_divisor  <= {DATA_W{1'b0}};
      r_rem      <= {DATA_W{1'b0}};
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_result   <= {(2*DATA_W){1'b0}};
      r_ready    <= DIV_RESULT_NOT_READY;
      r_busy     <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      r_by_zero  <= 1'b0;
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_busy <= (w_state_nxt == DIV_ON) || (w_state_nxt == DIV_BY_ZERO);
      case (r_state)
        DIV_FREE: begin
          r_ready  <= DIV_RESULT_NOT_READY;
          r_result <= {(2*DATA_W){1'b0}};
`ifdef DIV_ZERO_FLAG_EN
          r_div_zero <= 1'b0;
`endif
          if (w_accept) begin
            r_sign_q   <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            r_sign_r   <= signed_div_i & opdata1_i[DATA_W-1];
            r_dividend <= w_op1_abs;
            r_divisor  <= w_op2_abs;
            r_rem      <= {DATA_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
`ifdef DIV_ZERO_FLAG_EN
            r_by_zero  <= w_op2_zero;
`endif
          end
        end
        DIV_BY_ZERO: begin
          r_dividend <= {DATA_W{1'b0}};
          r_rem      <= {DATA_W{1'b0}};
        end
        DIV_ON: begin
          if (annul_i) begin
            r_ready  <= DIV_RESULT_NOT_READY;
            r_result <= {(2*DATA_W){1'b0}};
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
              r_dividend <= neg_if(r_sign_q, w_quo_nxt);
              r_rem      <= neg_if(r_sign_r, w_step_rem);
            end else begin
              r_dividend <= w_quo_nxt;
              r_rem      <= w_step_rem;
            end
          end
        end
        DIV_END: begin
          if (start_i == DIV_START) begin
            r_ready  <= DIV_RESULT_READY;
            r_result <= {r_rem, r_dividend};
`ifdef DIV_ZERO_FLAG_EN
            r_div_zero <= r_by_zero;
`endif
          end else begin
            r_ready  <= DIV_RESULT_NOT_READY;
            r_result <= {(2*DATA_W){1'b0}};
`ifdef DIV_ZERO_FLAG_EN
            r_div_zero <= 1'b0;
`endif
          end
        end
        default: begin
          r_ready  <= DIV_RESULT_NOT_READY;
          r_result <= {(2*DATA_W){1'b0}};
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = r_busy;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed scenarios plus randomized
// operations scored against an arithmetic reference model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic        div_zero_o;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DIV_ZERO_FLAG_EN
  localparam logic DZ_EN = 1'b1;
`else
  localparam logic DZ_EN = 1'b0;
`endif

  div_ctrl #(.DATA_W(32)) dut (
    .clk          (clk),
    .clr          (clr),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .div_zero_o   (div_zero_o)
  );

  always #5 clk = ~clk;

  // Truncating division; remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called just after a falling edge; returns once ready_o is seen or the budget expires.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n, output logic [63:0] res, output logic dz);
    int n;
    n = 0;
    busy_n = 0;
    signed_div_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    annul_i = 1'b0;
    start_i = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~sgn;
      end
      if (busy_o) busy_n++;
    end while (!ready_o && n < 60);
    lat = n - 1;
    res = result_o;
    dz = div_zero_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({ready_o, busy_o, div_zero_o, result_o} !== 67'd0)
      $display("FAIL reset_held: got ready=%b busy=%b dz=%b result=%h, need all 0", ready_o, busy_o, div_zero_o, result_o);
    else n_pass++;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready_o, busy_o, div_zero_o, result_o} !== 67'd0)
      $display("FAIL reset_release: got ready=%b busy=%b dz=%b result=%h, need all 0", ready_o, busy_o, div_zero_o, result_o);
    else n_pass++;
  endtask

  task automatic test_unsigned();
    int lat, bn;
    logic [63:0] res;
    logic dz;
    do_div(1'b0, 32'd100, 32'd7, lat, bn, res, dz);
    n_checks++;
    if (lat !== 33) $display("FAIL udiv_latency: got %0d need 33", lat); else n_pass++;
    n_checks++;
    if (bn !== 32) $display("FAIL udiv_busy_cycles: got %0d need 32", bn); else n_pass++;
    n_checks++;
    if (res !== {32'd2, 32'd14}) $display("FAIL udiv_result: got %h need %h", res, {32'd2, 32'd14}); else n_pass++;
    n_checks++;
    if (dz !== 1'b0) $display("FAIL udiv_dz: got %b need 0", dz); else n_pass++;
    start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ready_o, result_o} !== 65'd0) $display("FAIL udiv_release: got ready=%b result=%h need 0", ready_o, result_o); else n_pass++;
  endtask

  task automatic test_signed();
    logic [31:0] a_tab [2] = '{32'hFFFF_FFF9, 32'd7};
    logic [31:0] b_tab [2] = '{32'd2, 32'hFFFF_FFFE};
    logic [63:0] e_tab [2] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0000_0001, 32'hFFFF_FFFD}};
    int lat, bn;
    logic [63:0] res;
    logic dz;
    for (int i = 0; i < 2; i++) begin
      do_div(1'b1, a_tab[i], b_tab[i], lat, bn, res, dz);
      n_checks++;
      if (res !== e_tab[i]) $display("FAIL sdiv_result_%0d: got %h need %h", i, res, e_tab[i]); else n_pass++;
      n_checks++;
      if (lat !== 33) $display("FAIL sdiv_latency_%0d: got %0d need 33", i, lat); else n_pass++;
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] a_tab [2] = '{32'h8000_0000, 32'h1234_5678};
    int lat, bn;
    logic [63:0] res;
    logic dz;
    for (int i = 0; i < 2; i++) begin
      do_div(i[0], a_tab[i], 32'd0, lat, bn, res, dz);
      n_checks++;
      if (lat !== 2) $display("FAIL dz_latency_%0d: got %0d need 2", i, lat); else n_pass++;
      n_checks++;
      if (res !== 64'd0) $display("FAIL dz_result_%0d: got %h need 0", i, res); else n_pass++;
      n_checks++;
      if (dz !== DZ_EN) $display("FAIL dz_flag_%0d: got %b need %b", i, dz, DZ_EN); else n_pass++;
      n_checks++;
      if (bn !== 1) $display("FAIL dz_busy_%0d: got %0d need 1", i, bn); else n_pass++;
      start_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ready_o, div_zero_o} !== 2'b00) $display("FAIL dz_release_%0d: got ready=%b dz=%b need 0 0", i, ready_o, div_zero_o); else n_pass++;
    end
  endtask

  task automatic test_annul();
    int lat, bn, seen;
    logic [63:0] res;
    logic dz;
    signed_div_i = 1'b0;
    opdata1_i = 32'hFFFF_FFFF;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy_o, ready_o, result_o} !== 66'd0)
      $display("FAIL annul_abort: got busy=%b ready=%b result=%h need 0", busy_o, ready_o, result_o);
    else n_pass++;
    start_i = 1'b0;
    annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen = 1;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL annul_no_ready: got ready seen=%0d need 0", seen); else n_pass++;
    do_div(1'b0, 32'd9, 32'd3, lat, bn, res, dz);
    n_checks++;
    if (res !== {32'd0, 32'd3} || lat !== 33)
      $display("FAIL annul_fresh: got result=%h lat=%0d need %h lat=33", res, lat, {32'd0, 32'd3});
    else n_pass++;
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat, bn;
    logic [63:0] res, exp;
    logic dz;
    signed_div_i = 1'b0;
    opdata1_i = 32'h1234_5678;
    opdata2_i = 32'h0000_0123;
    start_i = 1'b1;
    repeat (15) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL rst_mid_busy_before: got %b need 1", busy_o); else n_pass++;
    #2;
    clr = 1'b1;
    start_i = 1'b0;
    #1;
    n_checks++;
    if ({ready_o, busy_o, div_zero_o, result_o} !== 67'd0)
      $display("FAIL rst_mid_async: got ready=%b busy=%b dz=%b result=%h need 0", ready_o, busy_o, div_zero_o, result_o);
    else n_pass++;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready_o, busy_o} !== 2'b00) $display("FAIL rst_mid_idle: got ready=%b busy=%b need 0 0", ready_o, busy_o); else n_pass++;
    exp = ref_div(1'b1, 32'hFFFF_FF9C, 32'd9);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd9, lat, bn, res, dz);
    n_checks++;
    if (res !== exp || lat !== 33) $display("FAIL rst_mid_after: got result=%h lat=%0d need %h lat=33", res, lat, exp); else n_pass++;
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    logic [63:0] res, exp;
    logic dz;
    exp = ref_div(1'b0, 32'd1000, 32'd33);
    do_div(1'b0, 32'd1000, 32'd33, lat, bn, res, dz);
    n_checks++;
    if (res !== exp) $display("FAIL hold_first: got %h need %h", res, exp); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready_o !== 1'b1 || result_o !== exp)
        $display("FAIL hold_stable_%0d: got ready=%b result=%h need 1 %h", i, ready_o, result_o, exp);
      else n_pass++;
    end
    start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ready_o, result_o} !== 65'd0) $display("FAIL hold_drop: got ready=%b result=%h need 0", ready_o, result_o); else n_pass++;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn, res, dz);
    n_checks++;
    if (res !== {32'd0, 32'h8000_0000} || lat !== 33)
      $display("FAIL b2b_wrap: got result=%h lat=%0d need %h lat=33", res, lat, {32'd0, 32'h8000_0000});
    else n_pass++;
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bn, exp_lat;
    logic [63:0] res, exp;
    logic dz, sgn;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: b = 32'h8000_0000;
        default: b = 32'($urandom);
      endcase
      exp = ref_div(sgn, a, b);
      exp_lat = (b == 32'd0) ? 2 : 33;
      do_div(sgn, a, b, lat, bn, res, dz);
      n_checks++;
      if (res !== exp || lat !== exp_lat || dz !== (DZ_EN && b == 32'd0))
        $display("FAIL rand_%0d: sgn=%b %h/%h got result=%h lat=%0d dz=%b need %h lat=%0d dz=%b",
                 i, sgn, a, b, res, lat, dz, exp, exp_lat, DZ_EN && b == 32'd0);
      else n_pass++;
      start_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ready_o !== 1'b0) $display("FAIL rand_release_%0d: got ready=%b need 0", i, ready_o); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle iterative divider with its sequencing FSM for DIV/DIVU.
- Sits beside the EX stage.
- EX holds start_i while it stalls the pipeline, and releases the stall when ready_o is high.
- Result is written to HI/LO: HI = remainder, LO = quotient.

Parameters:
DATA_W, 32, operand width; also the iteration count.

Ports:
clk  in  1  clock; all state updates on rising edge.
clr  in  1  asynchronous active-high reset.
signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
opdata1_i  in  DATA_W  dividend; sampled when start is accepted.
opdata2_i  in  DATA_W  divisor; sampled when start is accepted.
start_i  in  1  request, level; held high by EX until ready_o is seen.
annul_i  in  1  abort request (flush / exception).
result_o  out  2*DATA_W  {remainder, quotient}; valid only while ready_o = 1.
ready_o  out  1  result valid.
busy_o  out  1  high in BYZERO and ON.
div_zero_o  out  1  divide-by-zero flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, clr).
- All outputs are registered.
- Reset (clr = 1, any state, including mid-division):
  - state = FREE, cnt = 0.
  - result_o = 0, ready_o = 0, busy_o = 0, div_zero_o = 0.
  - Internal dividend/divisor/remainder registers = 0.
- States, 2-bit encoding in the shared defines: FREE = 00, BYZERO = 01, ON = 10, END = 11.
- FREE:
  - ready_o = 0.
  - If start_i = 1 and annul_i = 0:
    - Latch signs: sign_q = op1[MSB] ^ op2[MSB], sign_r = op1[MSB]; both forced to 0 when signed_div_i = 0.
    - If signed_div_i = 1, latch absolute values of the operands (two's complement negate of negative ones); otherwise latch the raw operands.
    - If divisor == 0, go to BYZERO; else go to ON with cnt = 0 and partial remainder = 0.
  - If start_i = 1 and annul_i = 1: remain in FREE.
- BYZERO:
  - Go to END next cycle with result = 0 (quotient 0, remainder 0).
  - Set div_zero_o when the feature is enabled.
- ON, one restoring step per cycle:
  - Shift {rem, dividend} left by 1, giving a (DATA_W+1)-bit trial = rem_shifted - divisor.
  - If trial is non-negative: rem = trial, shift 1 into the quotient; else keep rem, shift in 0.
  - cnt increments each cycle. When cnt = DATA_W-1 is completed, go to END with the raw quotient and remainder.
  - On entering END, apply signs: quotient negated if sign_q; remainder negated if sign_r.
  - annul_i = 1 in ON: go to FREE next edge, result_o = 0, ready_o stays 0. No partial result is ever exposed.
- END:
  - ready_o = 1 and result_o is held.
  - Stay while start_i = 1. When start_i = 0, go to FREE and clear ready_o and result_o on that edge.
  - annul_i is ignored in END (the result is already committed to the HI/LO path).
- Latency, counted from the edge that samples start_i in FREE:
  - ready_o rises DATA_W+1 edges later (33 for DATA_W = 32).
  - Divisor zero: ready_o rises 2 edges later.
- Signed edge case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is the natural wrap; no trap.
- Back-to-back: after END → FREE, a new start is accepted in the FREE cycle. Minimum one idle cycle between results.
- Input changes on op/signed_div_i after acceptance have no effect.

Optional Feature:
DIV_ZERO_FLAG_EN:
- Defined: div_zero_o = 1 in END when the accepted divisor was 0; cleared when leaving END.
- Undefined: div_zero_o is tied to 0 and the BYZERO path is identical except for the flag.
- The port is always present, so the interface is stable either way.

Decomposition:
- defines.v gets the state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/NotReady, DivStart/DivStop.
- EX-side aluop codes EXE_DIV_OP/EXE_DIVU_OP already belong there.
- One natural sub-module: div_step. It is combinational: takes the shifted remainder and the divisor, and returns the new remainder and the quotient bit.
- Sign fix-up and the FSM stay in div_ctrl.

Test Plan:
- Unsigned 100 / 7 → ready_o after 33 edges, result_o = {32'd2, 32'd14}; busy_o high for cycles 1..32.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) → result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Also signed 7 / -2 → {32'h1, 32'hFFFFFFFD}.
- Divisor 0, any dividend → ready_o at edge 2, result_o = 0, div_zero_o = 1 only when DIV_ZERO_FLAG_EN is defined.
- Annul: start 0xFFFFFFFF / 3, assert annul_i at cycle 10 → FREE next edge, ready_o never rises. A fresh 9 / 3 start then returns {0, 3}.
- Reset mid-op: assert clr asynchronously at cycle 15, between edges → all outputs 0 immediately; FSM in FREE after release.
- Hold/back-to-back: keep start_i high 5 cycles in END → result_o stable. Drop start_i → ready_o = 0 next edge. Immediate new start 0x80000000 / 0xFFFFFFFF signed → {0, 32'h80000000}.
